// File: rtl/floo_ring_on_mesh_mcast_fork.sv
// ---------------------------------------------------------------------------
// floo_ring_on_mesh_mcast_fork
//
// Replicates one ring-on-mesh flit onto every output port set in a (possibly
// multi-hot) route mask. Each port handshakes on its own. Ports that have
// already accepted the current flit are remembered in sent_q, so a port never
// receives the same flit twice. The input flit retires only once every
// selected port has taken it. An empty mask drops the flit and bumps a counter.
//
// Handshake: a transfer on a port happens in a cycle where valid and ready are
// both high. valid never waits for ready and is never withdrawn before it is
// accepted. ready_o means the input flit is consumed in this cycle.
//
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   valid_i        input flit valid
//   ready_o        input flit consumed this cycle (combinational from ready_i)
//   channel_i      input flit
//   route_sel_i    route mask (bit0 = eject)
//   valid_o        per-port valid
//   ready_i        per-port ready
//   channel_o      flit shared by all ports (pass-through)
//   drop_cnt_o     saturating count of flits retired with an empty mask
//   mcast_cnt_o    saturating count of flits retired with >1 mask bit set
//   sel_err_o      sticky: route mask changed, or valid dropped, mid-fork
//
// Debug: the FSM state is derived from sent_q. It is visible as the signal
// 'state' (IDLE / PARTIAL) and as the register sent_q.
// ---------------------------------------------------------------------------
module floo_ring_on_mesh_mcast_fork #(
  parameter int unsigned NumRoutes = 5,
  parameter type         flit_t    = logic,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  flit_t                channel_i,
  input  logic [NumRoutes-1:0] route_sel_i,
  output logic [NumRoutes-1:0] valid_o,
  input  logic [NumRoutes-1:0] ready_i,
  output flit_t                channel_o,
  output logic [CntWidth-1:0]  drop_cnt_o,
  output logic [CntWidth-1:0]  mcast_cnt_o,
  output logic                 sel_err_o
);

  typedef enum logic {IDLE = 1'b0, PARTIAL = 1'b1} state_e;

  localparam logic [NumRoutes-1:0] OneSel = NumRoutes'(1);
  localparam logic [CntWidth-1:0]  OneCnt = CntWidth'(1);

  state_e               state;
  logic [NumRoutes-1:0] sent_q, sent_d;
  logic [NumRoutes-1:0] sel_q, sel_d;
  logic                 sel_err_q, sel_err_d;
  logic [CntWidth-1:0]  drop_cnt_q, mcast_cnt_q;

  logic [NumRoutes-1:0] vld, hs;
  logic                 done, retire, is_drop, is_mcast;

  // Combinational datapath and next-state logic.
  always_comb begin
    state     = (sent_q == '0) ? IDLE : PARTIAL;
    vld       = {NumRoutes{valid_i}} & route_sel_i & ~sent_q;
    hs        = vld & ready_i;
    // A port is finished if it is not selected, was served earlier, or is
    // being served now. The flit is done when every port is finished.
    done      = &(~route_sel_i | sent_q | hs);
    retire    = valid_i & done & ~rst_i;
    is_drop   = (route_sel_i == '0);
    // Clearing the lowest set bit leaves something only if >1 bit was set.
    is_mcast  = |(route_sel_i & (route_sel_i - OneSel));

    sent_d    = sent_q;
    sel_d     = sel_q;
    sel_err_d = sel_err_q;
    unique case (state)
      IDLE: begin
        if (valid_i && !done && (hs != '0)) begin
          sent_d = hs;
          sel_d  = route_sel_i;
        end
      end
      PARTIAL: begin
        sent_d = done ? '0 : (sent_q | hs);
        // Upstream must hold the flit and its mask steady until it retires.
        // The fork keeps following the live mask after flagging the error.
        if ((route_sel_i != sel_q) || !valid_i) sel_err_d = 1'b1;
      end
      default: sent_d = '0;
    endcase

    // Outputs are held low while reset is asserted.
    valid_o   = rst_i ? '0 : vld;
    ready_o   = retire;
    channel_o = channel_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sent_q      <= '0;
      sel_q       <= '0;
      sel_err_q   <= 1'b0;
      drop_cnt_q  <= '0;
      mcast_cnt_q <= '0;
    end else begin
      sent_q    <= sent_d;
      sel_q     <= sel_d;
      sel_err_q <= sel_err_d;
      if (retire && is_drop && (drop_cnt_q != '1))
        drop_cnt_q <= drop_cnt_q + OneCnt;
      if (retire && is_mcast && (mcast_cnt_q != '1))
        mcast_cnt_q <= mcast_cnt_q + OneCnt;
    end
  end

  assign drop_cnt_o  = drop_cnt_q;
  assign mcast_cnt_o = mcast_cnt_q;
  assign sel_err_o   = sel_err_q;

endmodule

// File: tb/tb_floo_ring_on_mesh_mcast_fork.sv
// ---------------------------------------------------------------------------
// tb_floo_ring_on_mesh_mcast_fork
//
// Directed bench for the multicast fork. Two instances share every input:
// u_a uses 16-bit counters and u_b uses 2-bit counters, so counter saturation
// shows up on u_b. Inputs change 1 ns after a rising edge. Combinational
// outputs are checked 1 ns after that, and registered outputs 1 ns after the
// edge.
// ---------------------------------------------------------------------------
module tb_floo_ring_on_mesh_mcast_fork;

  localparam int NR = 5;
  typedef logic [7:0] flit_t;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  flit_t         channel_i = '0;
  logic [NR-1:0] route_sel_i = '0;
  logic [NR-1:0] ready_i = '0;

  logic          ready_a, ready_b, err_a, err_b;
  logic [NR-1:0] valid_a, valid_b;
  flit_t         chan_a, chan_b;
  logic [15:0]   drop_a, mcast_a;
  logic [1:0]    drop_b, mcast_b;

  int n_chk = 0;
  int n_err = 0;

  // -------------------------------------------------------------------------
  // Clock
  // -------------------------------------------------------------------------
  always #5 clk_i = ~clk_i;

  // -------------------------------------------------------------------------
  // Devices under test
  // -------------------------------------------------------------------------
  floo_ring_on_mesh_mcast_fork #(.NumRoutes(NR), .flit_t(flit_t), .CntWidth(16)) u_a (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_a),
    .channel_i(channel_i), .route_sel_i(route_sel_i), .valid_o(valid_a),
    .ready_i(ready_i), .channel_o(chan_a), .drop_cnt_o(drop_a),
    .mcast_cnt_o(mcast_a), .sel_err_o(err_a)
  );

  floo_ring_on_mesh_mcast_fork #(.NumRoutes(NR), .flit_t(flit_t), .CntWidth(2)) u_b (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_b),
    .channel_i(channel_i), .route_sel_i(route_sel_i), .valid_o(valid_b),
    .ready_i(ready_i), .channel_o(chan_b), .drop_cnt_o(drop_b),
    .mcast_cnt_o(mcast_b), .sel_err_o(err_b)
  );

  // -------------------------------------------------------------------------
  // Check and driver tasks
  // -------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs 1 ns after the rising edge, then settle for 1 ns.
  task automatic drive(input logic v, input logic [NR-1:0] sel, input logic [NR-1:0] rdy);
    valid_i     = v;
    route_sel_i = sel;
    ready_i     = rdy;
    channel_i   = flit_t'($urandom_range(0, 255));
    #1;
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Check comb outputs on both instances against expected values.
  task automatic chk_comb(input string tag, input logic [NR-1:0] ev, input logic er);
    chk({tag, "_valid_a"}, 32'(valid_a), 32'(ev));
    chk({tag, "_ready_a"}, 32'(ready_a), 32'(er));
    chk({tag, "_valid_b"}, 32'(valid_b), 32'(ev));
    chk({tag, "_ready_b"}, 32'(ready_b), 32'(er));
  endtask

  // -------------------------------------------------------------------------
  // Scoreboard for the random back-pressure phase
  // -------------------------------------------------------------------------
  logic [NR-1:0] exp_q[$];
  logic [NR-1:0] model_sent, seen, exp_v, cur_mask, rdy, hs_m;
  logic          exp_r;
  int            exp_mcast;

  initial begin
    // ---------------- reset ----------------
    drive(1'b1, 5'b01001, 5'b11111);
    chk_comb("rst", 5'b00000, 1'b0);
    chk("rst_drop_a", 32'(drop_a), 0);
    chk("rst_mcast_a", 32'(mcast_a), 0);
    chk("rst_err_a", 32'(err_a), 0);
    tick();
    tick();
    rst_i = 1'b0;

    // ---------------- 1: unicast ----------------
    drive(1'b1, 5'b00100, 5'b11111);
    chk_comb("uni", 5'b00100, 1'b1);
    chk("uni_chan", 32'(chan_a), 32'(channel_i));
    tick();
    chk("uni_drop", 32'(drop_a), 0);
    chk("uni_mcast", 32'(mcast_a), 0);
    chk("uni_sent", 32'(u_a.sent_q), 0);

    // ---------------- 2: multicast, partial then complete ----------------
    drive(1'b1, 5'b01001, 5'b00001);
    chk_comb("mc0", 5'b01001, 1'b0);
    tick();
    chk("mc0_sent", 32'(u_a.sent_q), 32'b00001);
    drive(1'b1, 5'b01001, 5'b01000);
    chk_comb("mc1", 5'b01000, 1'b1);
    tick();
    chk("mc1_mcast", 32'(mcast_a), 1);
    chk("mc1_sent", 32'(u_a.sent_q), 0);
    chk("mc1_err", 32'(err_a), 0);

    // ---------------- 3: three drops ----------------
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'b00000, 5'b00000);
      chk_comb("drop", 5'b00000, 1'b1);
      tick();
    end
    chk("drop3_a", 32'(drop_a), 3);
    chk("drop3_b", 32'(drop_b), 3);

    // ---------------- 4: saturation on 2-bit counter ----------------
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 5'b00000, 5'b11111);
      tick();
    end
    chk("drop5_a", 32'(drop_a), 5);
    chk("drop5_sat_b", 32'(drop_b), 3);

    // Simultaneous last accepts retire in the same cycle.
    drive(1'b1, 5'b10110, 5'b00010);
    chk_comb("sim0", 5'b10110, 1'b0);
    tick();
    drive(1'b1, 5'b10110, 5'b10100);
    chk_comb("sim1", 5'b10100, 1'b1);
    tick();
    chk("sim_mcast_a", 32'(mcast_a), 2);
    chk("sim_sent", 32'(u_a.sent_q), 0);

    // All ports ready: full multicast retires in one cycle.
    drive(1'b1, 5'b11111, 5'b11111);
    chk_comb("all", 5'b11111, 1'b1);
    tick();
    chk("all_mcast_a", 32'(mcast_a), 3);
    drive(1'b1, 5'b00011, 5'b00011);
    tick();
    chk("mc_mcast_a", 32'(mcast_a), 4);
    chk("mc_sat_b", 32'(mcast_b), 3);
    chk("mc_drop_a", 32'(drop_a), 5);

    // ---------------- 5: protocol error ----------------
    drive(1'b1, 5'b00011, 5'b00001);
    chk_comb("err0", 5'b00011, 1'b0);
    tick();
    chk("err0_flag", 32'(err_a), 0);
    drive(1'b1, 5'b00010, 5'b00000);
    chk_comb("err1", 5'b00010, 1'b0);
    tick();
    chk("err1_flag_a", 32'(err_a), 1);
    chk("err1_flag_b", 32'(err_b), 1);
    drive(1'b1, 5'b00010, 5'b00010);
    chk_comb("err2", 5'b00010, 1'b1);
    tick();
    drive(1'b0, 5'b00000, 5'b00000);
    tick();
    chk("err_sticky", 32'(err_a), 1);
    chk("err_mcast_a", 32'(mcast_a), 4);

    // ---------------- 6: reset mid-fork ----------------
    drive(1'b1, 5'b01001, 5'b00001);
    tick();
    chk("rmf_sent", 32'(u_a.sent_q), 32'b00001);
    rst_i   = 1'b1;
    ready_i = 5'b00000;
    #1;
    chk_comb("rmf_rst", 5'b00000, 1'b0);
    chk("rmf_err", 32'(err_a), 0);
    chk("rmf_drop", 32'(drop_a), 0);
    chk("rmf_mcast", 32'(mcast_a), 0);
    tick();
    rst_i = 1'b0;
    #1;
    chk_comb("rmf_resend", 5'b01001, 1'b0);
    ready_i = 5'b11111;
    #1;
    chk_comb("rmf_done", 5'b01001, 1'b1);
    tick();
    chk("rmf_mcast1", 32'(mcast_a), 1);

    // ---------------- random back-pressure ----------------
    exp_mcast  = 1;
    for (int f = 0; f < 40; f++) begin
      cur_mask = NR'($urandom_range(1, 31));
      exp_q.push_back(cur_mask);
      model_sent = '0;
      seen       = '0;
      for (int c = 0; c < 40; c++) begin
        rdy = (c >= 20) ? 5'b11111 : NR'($urandom_range(0, 31));
        drive(1'b1, cur_mask, rdy);
        exp_v = cur_mask & ~model_sent;
        hs_m  = exp_v & rdy;
        exp_r = &(~cur_mask | model_sent | hs_m);
        chk_comb("rnd", exp_v, exp_r);
        seen = seen | (valid_a & ready_i);
        tick();
        model_sent = exp_r ? '0 : (model_sent | hs_m);
        if (exp_r) break;
      end
      chk("rnd_once", 32'(seen), 32'(exp_q.pop_front()));
      if ((cur_mask & (cur_mask - 5'b00001)) != '0) exp_mcast++;
    end
    chk("rnd_mcast", 32'(mcast_a), 32'(exp_mcast));
    chk("rnd_err", 32'(err_a), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
